// File: rtl/register_bank.sv
// register_bank: 64-entry (2**ADDR_WIDTH) register file with two combinational read ports,
// one write port and a sequential clear engine that zeroes one entry per cycle after reset.
// Latency: reads are zero-cycle combinational. Writes land on the rising edge.
// Backpressure: Busy is high while the clear engine runs. Writes are dropped (not queued) and reads return 0.
// Optional feature: define REG_BANK_BYPASS_EN for a same-cycle write-through bypass on each read port.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2,
    input  logic [ADDR_WIDTH-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Reg_Write,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2,
    output logic                  Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_idx_q, clear_idx_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    clear_en;
    logic                    wr_en;

    // Reset has priority over both the clear engine and the write port.
    assign clear_en = (state_q == ST_CLEAR) && !Reset;
    assign wr_en    = (state_q == ST_IDLE) && !Reset && Reg_Write
                      && (Write_Register != '0);

    // Next-state for the clear engine: walk every index once, then go idle with the index wrapped to 0.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        busy_d      = busy_q;
        if (Reset) begin
            state_d     = ST_CLEAR;
            clear_idx_d = '0;
            busy_d      = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (&clear_idx_q) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // FSM state, clear index and the registered Busy flag.
    // Busy is a flop, so there is no combinational path from Reset to Busy.
    always_ff @(posedge Clock) begin
        state_q     <= state_d;
        clear_idx_q <= clear_idx_d;
        busy_q      <= busy_d;
    end

    assign Busy = busy_q;

    // Storage update: the clear engine owns the array while clearing; otherwise the write port does.
    always_ff @(posedge Clock) begin
        if (clear_en) begin
            mem_q[clear_idx_q] <= '0;
        end else if (wr_en) begin
            mem_q[Write_Register] <= Write_Data;
        end
    end

    // Read ports:
    //  - Index 0 always reads 0.
    //  - While clearing, every index reads 0, so entries not yet cleared never leak out.
    always_comb begin
        Read_Data_1 = '0;
        Read_Data_2 = '0;
        if (state_q == ST_IDLE) begin
            if (Read_Register_1 != '0) begin
                Read_Data_1 = mem_q[Read_Register_1];
            end
            if (Read_Register_2 != '0) begin
                Read_Data_2 = mem_q[Read_Register_2];
            end
`ifdef REG_BANK_BYPASS_EN
            // The write-through applies only to real writes, which excludes index 0 and the clearing phase.
            // Each port matches independently.
            if (wr_en && (Read_Register_1 == Write_Register)) begin
                Read_Data_1 = Write_Data;
            end
            if (wr_en && (Read_Register_2 == Write_Register)) begin
                Read_Data_2 = Write_Data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank. Inputs are driven 1ns after the rising edge.
// Outputs are checked 1ns after that, well clear of the next edge.
`timescale 1ns/1ps
module tb_register_bank;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          Clock;
    logic          Reset;
    logic [AW-1:0] Read_Register_1;
    logic [AW-1:0] Read_Register_2;
    logic [AW-1:0] Write_Register;
    logic [DW-1:0] Write_Data;
    logic          Reg_Write;
    logic [DW-1:0] Read_Data_1;
    logic [DW-1:0] Read_Data_2;
    logic          Busy;

    int vectors;
    int miscompares;

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Read_Register_1 (Read_Register_1),
        .Read_Register_2 (Read_Register_2),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data),
        .Reg_Write       (Reg_Write),
        .Read_Data_1     (Read_Data_1),
        .Read_Data_2     (Read_Data_2),
        .Busy            (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs 64 edges after a reset release.
    // Busy must still be 1 after edge 63 and must be 0 after edge 64.
    task automatic run_clear(input string tag);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) check({tag, "_busy_at_63"}, {31'b0, Busy}, 32'd1);
            if (i == 64) check({tag, "_busy_at_64"}, {31'b0, Busy}, 32'd0);
        end
    endtask

    logic [DW-1:0] bypass_exp;

    initial begin
        vectors         = 0;
        miscompares     = 0;
        Reset           = 1'b1;
        Read_Register_1 = '0;
        Read_Register_2 = '0;
        Write_Register  = '0;
        Write_Data      = '0;
        Reg_Write       = 1'b0;

        // Reset sequence: Reset is held for two edges.
        tick();
        tick();
        Read_Register_1 = 6'd10;
        Read_Register_2 = 6'd63;
        #1;
        check("reset_busy", {31'b0, Busy}, 32'd1);
        check("reset_rd1", Read_Data_1, 32'h0);
        check("reset_rd2", Read_Data_2, 32'h0);

        // The release is followed by the clear.
        // A write to reg 5 is held asserted through every clear edge and must be dropped.
        Reset          = 1'b0;
        Reg_Write      = 1'b1;
        Write_Register = 6'd5;
        Write_Data     = 32'hDEADBEEF;
        Read_Register_1 = 6'd5;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 10) begin
                #1;
                check("clear_read_rd1", Read_Data_1, 32'h0);
            end
            if (i == 63) check("clear_busy_at_63", {31'b0, Busy}, 32'd1);
            if (i == 64) check("clear_busy_at_64", {31'b0, Busy}, 32'd0);
        end
        Reg_Write = 1'b0;

        // After the clear completes, every index must read 0.
        for (int j = 0; j < 64; j++) begin
            Read_Register_1 = AW'(j);
            Read_Register_2 = AW'(63 - j);
            #1;
            check($sformatf("post_clear_rd1_%0d", j), Read_Data_1, 32'h0);
            check($sformatf("post_clear_rd2_%0d", 63 - j), Read_Data_2, 32'h0);
        end
        Read_Register_1 = 6'd5;
        #1;
        check("write_during_clear_reg5", Read_Data_1, 32'h0);

        // Basic write followed by a read.
        Reg_Write      = 1'b1;
        Write_Register = 6'd10;
        Write_Data     = 32'h12345678;
        tick();
        Write_Register = 6'd63;
        Write_Data     = 32'hCAFEF00D;
        tick();
        Reg_Write       = 1'b0;
        Read_Register_1 = 6'd10;
        Read_Register_2 = 6'd63;
        #1;
        check("basic_rd1_reg10", Read_Data_1, 32'h12345678);
        check("basic_rd2_reg63", Read_Data_2, 32'hCAFEF00D);
        Read_Register_2 = 6'd10;
        #1;
        check("same_index_rd2", Read_Data_2, 32'h12345678);

        // Register 0 is hardwired to 0. Even a same-cycle read of index 0 gets no bypass.
        Reg_Write       = 1'b1;
        Write_Register  = 6'd0;
        Write_Data      = 32'hFFFFFFFF;
        Read_Register_1 = 6'd0;
        Read_Register_2 = 6'd0;
        #1;
        check("reg0_same_cycle_rd1", Read_Data_1, 32'h0);
        tick();
        Reg_Write = 1'b0;
        #1;
        check("reg0_rd1", Read_Data_1, 32'h0);
        check("reg0_rd2", Read_Data_2, 32'h0);

        // Same-cycle read of an index that is being written.
        // The bypass matches port 1 only; port 2 reads an unrelated register.
`ifdef REG_BANK_BYPASS_EN
        bypass_exp = 32'hA5A5A5A5;
`else
        bypass_exp = 32'h0;
`endif
        Reg_Write       = 1'b1;
        Write_Register  = 6'd7;
        Write_Data      = 32'hA5A5A5A5;
        Read_Register_1 = 6'd7;
        Read_Register_2 = 6'd10;
        #1;
        check("bypass_same_cycle_rd1", Read_Data_1, bypass_exp);
        check("bypass_other_port_rd2", Read_Data_2, 32'h12345678);
        tick();
        Reg_Write = 1'b0;
        #1;
        check("bypass_next_cycle_rd1", Read_Data_1, 32'hA5A5A5A5);

        // Reset in the middle of a clear.
        // Reset pulses once, and 30 clear edges later it is reasserted together with a write.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Read_Register_2 = 6'd63;
        for (int i = 1; i <= 30; i++) begin
            tick();
        end
        #1;
        check("midclear_rd2_uncleared", Read_Data_2, 32'h0);
        check("midclear_busy", {31'b0, Busy}, 32'd1);
        Reset          = 1'b1;
        Reg_Write      = 1'b1;
        Write_Register = 6'd20;
        Write_Data     = 32'h55AA55AA;
        tick();
        check("rereset_busy", {31'b0, Busy}, 32'd1);
        Reset     = 1'b0;
        Reg_Write = 1'b0;
        run_clear("rereset");
        Read_Register_1 = 6'd10;
        Read_Register_2 = 6'd63;
        #1;
        check("rereset_reg10", Read_Data_1, 32'h0);
        check("rereset_reg63", Read_Data_2, 32'h0);
        Read_Register_1 = 6'd7;
        Read_Register_2 = 6'd20;
        #1;
        check("rereset_reg7", Read_Data_1, 32'h0);
        check("rereset_reg20", Read_Data_2, 32'h0);

        // The write port must still work after the second clear.
        Reg_Write      = 1'b1;
        Write_Register = 6'd20;
        Write_Data     = 32'h0BADCAFE;
        tick();
        Reg_Write = 1'b0;
        #1;
        check("post_rereset_write_reg20", Read_Data_2, 32'h0BADCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
